// File: rtl/instr_dec_buf_pkg.sv
// -----------------------------------------------------------------------------
// instr_dec_buf_pkg
// Shared definitions for the decode-stage input buffer:
//   - instruction / data widths
//   - RV32 major opcode constants used by the immediate-type classifier
//   - occupancy state encoding, immediate-flag and buffered-entry structs
//   - opcode_of(): extracts the major opcode field from an instruction word
// -----------------------------------------------------------------------------
package instr_dec_buf_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int DATA_WIDTH  = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Occupancy state; the encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // One-hot immediate class (at most one bit set).
  typedef struct packed {
    logic is_i;
    logic is_s;
    logic is_b;
    logic is_j;
    logic is_u;
  } imm_flags_t;

  // Decoded entry as stored in the head/tail registers.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0]  pc;
    imm_flags_t             flags;
    logic                   illegal;
  } dec_entry_t;

  function automatic logic [6:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/instr_dec_buf_type_dec.sv
// -----------------------------------------------------------------------------
// instr_type_dec
// Purely combinational opcode classifier. Maps a major opcode to one of the
// immediate classes (I/S/B/J/U) or to "no immediate". Opcodes outside the
// supported set raise illegal_o with all class flags cleared.
// Ports:
//   opcode_i   in   7            major opcode (instr[6:0])
//   flags_o    out  imm_flags_t  one-hot immediate class
//   illegal_o  out  1            opcode not recognised
// -----------------------------------------------------------------------------
module instr_type_dec
  import instr_dec_buf_pkg::*;
(
  input  logic [6:0] opcode_i,
  output imm_flags_t flags_o,
  output logic       illegal_o
);

  always_comb begin
    flags_o   = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC:            flags_o.is_u = 1'b1;
      OPC_JAL:                       flags_o.is_j = 1'b1;
      OPC_BRANCH:                    flags_o.is_b = 1'b1;
      OPC_STORE:                     flags_o.is_s = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: flags_o.is_i = 1'b1;
      // Legal instructions that carry no immediate.
      OPC_OP, OPC_FENCE, OPC_SYSTEM: flags_o = '0;
      default:                       illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_dec_buf.sv
// -----------------------------------------------------------------------------
// instr_dec_buf
// Two-entry skid buffer between fetch and immediate generation. Instructions
// are classified on the way in and stored together with their flags; the head
// register drives all id_* outputs.
// Ports:
//   cpu_clk         in   1            core clock
//   cpu_rstn        in   1            synchronous active-low reset
//   if_valid        in   1            fetch presents an instruction
//   if_instr        in   INSTR_WIDTH  fetched instruction
//   if_pc           in   DATA_WIDTH   PC of if_instr
//   if_ready        out  1            buffer can accept this cycle
//   id_valid        out  1            head entry valid
//   id_ready        in   1            downstream consumes head this cycle
//   id_instr        out  INSTR_WIDTH  head instruction
//   id_pc           out  DATA_WIDTH   head PC
//   imm_is_*_type   out  1 each       head immediate class (one-hot or zero)
//   id_illegal      out  1            head opcode unrecognised
//   flush           in   1            discard all buffered entries
// -----------------------------------------------------------------------------
module instr_dec_buf
  import instr_dec_buf_pkg::*;
(
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic                   if_valid,
  input  logic [INSTR_WIDTH-1:0] if_instr,
  input  logic [DATA_WIDTH-1:0]  if_pc,
  output logic                   if_ready,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0]  id_pc,
  output logic                   imm_is_I_type,
  output logic                   imm_is_S_type,
  output logic                   imm_is_B_type,
  output logic                   imm_is_J_type,
  output logic                   imm_is_U_type,
  output logic                   id_illegal,
  input  logic                   flush
);

  occ_state_e state_q, state_d;
  dec_entry_t head_q, head_d;
  dec_entry_t tail_q, tail_d;
  dec_entry_t push_entry;

  logic [6:0] push_opcode;
  imm_flags_t dec_flags;
  logic       dec_illegal;
  logic       push;
  logic       pop;

  // Decode happens once, on the way in; the stored flags are what decode sees.
  assign push_opcode = opcode_of(if_instr);

  instr_type_dec u_type_dec (
    .opcode_i  (push_opcode),
    .flags_o   (dec_flags),
    .illegal_o (dec_illegal)
  );

  assign push_entry = '{instr: if_instr, pc: if_pc, flags: dec_flags, illegal: dec_illegal};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: handshakes depend only on the registered state, so there is
  // no combinational path from id_ready to if_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_ready = (state_q != OCC_TWO);
    id_valid = (state_q != OCC_EMPTY);
  end

  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic; flush overrides any same-cycle push or pop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (push) state_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      state_d = OCC_TWO;
          else if (!push && pop) state_d = OCC_EMPTY;
        end
        OCC_TWO:   if (pop) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head/tail data path. Registers hold their contents when not written, so a
  // flushed buffer keeps showing stale (don't-care) data with id_valid low.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (!flush) begin
      case (state_q)
        OCC_EMPTY: if (push) head_d = push_entry;
        OCC_ONE: begin
          // Push and pop together: the head leaves and the newcomer replaces it.
          if (push && pop) head_d = push_entry;
          else if (push)   tail_d = push_entry;
        end
        OCC_TWO:   if (pop) head_d = tail_q;
        default: begin
          head_d = head_q;
          tail_d = tail_q;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign id_instr      = head_q.instr;
  assign id_pc         = head_q.pc;
  assign imm_is_I_type = head_q.flags.is_i;
  assign imm_is_S_type = head_q.flags.is_s;
  assign imm_is_B_type = head_q.flags.is_b;
  assign imm_is_J_type = head_q.flags.is_j;
  assign imm_is_U_type = head_q.flags.is_u;
  assign id_illegal    = head_q.illegal;

endmodule

// File: doc/instr_dec_buf.md
# instr_dec_buf

Decode-stage input buffer sitting between instruction fetch and immediate generation. Accepts fetched instructions over a valid/ready handshake, classifies the opcode into one-hot immediate-type flags, and holds up to two decoded entries in a skid buffer. The head entry drives the immediate generator and the rest of decode. Supports pipeline flush on redirect.

## Interface
Parameters: none; widths come from `INSTR_WIDTH` (32) and `DATA_WIDTH` (32) in core_defines.vh.

Ports:
- cpu_clk  in  1  core clock; all state updates on rising edge
- cpu_rstn  in  1  reset, synchronous, active-low
- if_valid  in  1  fetch presents an instruction
- if_instr  in  `INSTR_WIDTH`  fetched instruction
- if_pc  in  `DATA_WIDTH`  PC of if_instr
- if_ready  out  1  buffer can accept this cycle
- id_valid  out  1  head entry valid
- id_ready  in  1  downstream consumes head this cycle
- id_instr  out  `INSTR_WIDTH`  head instruction
- id_pc  out  `DATA_WIDTH`  head PC
- imm_is_I_type, imm_is_S_type, imm_is_B_type, imm_is_J_type, imm_is_U_type  out  1 each  head immediate class, at most one set
- id_illegal  out  1  head opcode unrecognised
- flush  in  1  discard all buffered entries

## Operation
- Entry = {instr, pc, 5 type flags, illegal}. Decoding is done at push time; flags are stored, not recomputed at output.
- Opcode `instr[6:0]` mapping:
  - 0110111 LUI, 0010111 AUIPC → U
  - 1101111 JAL → J
  - 1100011 BRANCH → B
  - 0100011 STORE → S
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM → I
  - 0110011 OP, 0001111 FENCE, 1110011 SYSTEM → no flag, legal
  - anything else → no flag, id_illegal=1
- Occupancy states:
  - EMPTY (count 0):
    - push → ONE
  - ONE (count 1):
    - push without pop → TWO
    - pop without push → EMPTY
    - push and pop together → ONE, new entry becomes head
  - TWO (count 2):
    - pop → ONE, tail moves to head
    - push is impossible (if_ready=0)
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready = (count != 2), derived from registered count only; no combinational path from id_ready.
- id_valid = (count != 0). id_* outputs come from the head register.
- flush has priority over push and pop: count → 0 and any same-cycle push is dropped. if_ready=1 in the following cycle.
- When count 0, id_instr/id_pc/flags hold their last values but are don't-care. Verification checks them only when id_valid=1.
- Reset (cpu_rstn=0 at edge) has the same effect as flush and also clears head/tail data to 0. After reset: id_valid=0, if_ready=1, all flags 0, id_illegal=0, id_instr=0, id_pc=0.

## Timing
- Latency: instruction accepted at edge N appears on id_* after edge N and is consumable in cycle N+1.
- Throughput: 1 instruction/cycle sustained when id_ready stays high.
- Backpressure: if id_ready drops, one extra accepted instruction is absorbed into the tail. if_ready falls the cycle after count reaches 2.
- Order is strictly FIFO; no entry is duplicated or lost except on flush/reset.
- Reset asserted mid-stream clears state at the next edge regardless of if_valid/id_ready.

## Structure
- Opcode constants (`OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_BRANCH`, `OPC_LOAD`, `OPC_STORE`, `OPC_OPIMM`, `OPC_OP`, `OPC_FENCE`, `OPC_SYSTEM`) go in core_defines.vh.
- One combinational sub-module, instr_type_dec:
  - input: opcode
  - outputs: five type flags and illegal
  - instantiated once, on the push path.
- Head and tail registers plus a 2-bit count form the top level.

## Test plan
- Reset, then stream 0x000000B7 (LUI), 0x0000006F (JAL), 0x00000063 (BRANCH), 0x00000023 (STORE), 0x00000013 (ADDI) with id_ready=1 → each appears one cycle later with flags U, J, B, S, I respectively; id_valid continuous.
- Hold id_ready=0 while feeding 3 instructions → first two accepted, if_ready=0 from the cycle after the second. Release id_ready → outputs in order, no loss.
- Count=1, push and pop in the same cycle → count stays 1, head becomes the new instruction.
- Count=2 with flush=1 and if_valid=1 → next cycle id_valid=0, if_ready=1, flushed and pushed entries absent.
- Instruction 0x0000007F → id_illegal=1, all type flags 0. Instruction 0x00000033 (OP) → all 0, id_illegal=0.
- Drive cpu_rstn=0 for one cycle mid-stream with the buffer full → next cycle id_valid=0, id_instr=0, id_pc=0, if_ready=1.
